// File: rtl/mod_div_unit.sv
// rtl/mod_div_unit.sv - iterative restoring divider/modulo unit, one quotient bit per cycle
module mod_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             smode_q;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r;

  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted;
  logic             sub_ok;

  always_comb begin
    a_neg   = smode_q & a_q[WIDTH-1];
    b_neg   = smode_q & b_q[WIDTH-1];
    a_abs   = a_neg ? (~a_q + 1'b1) : a_q;
    b_abs   = b_neg ? (~b_q + 1'b1) : b_q;
    b_zero  = (b_q == '0);
    // Partial remainder is always < divisor, so the shifted value needs one extra bit.
    shifted = {rem, dvd[WIDTH-1]};
    sub_ok  = (shifted >= {1'b0, dvs});
  end

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = b_zero ? FIX : ITER;
      ITER:    if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      smode_q     <= 1'b0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            smode_q <= signed_mode;
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          dvd    <= a_abs;
          dvs    <= b_abs;
          rem    <= '0;
          count  <= CW'(WIDTH - 1);
          sign_q <= a_neg ^ b_neg;
          sign_r <= a_neg;
        end
        ITER: begin
          rem   <= sub_ok ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], sub_ok};
          count <= count - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (b_zero) begin
            quotient    <= '1;
            remainder   <= a_q;
            div_by_zero <= 1'b1;
          end else begin
            // MIN / -1 wraps back to MIN on negation, which is the intended result.
            quotient    <= sign_q ? (~dvd + 1'b1) : dvd;
            remainder   <= sign_r ? (~rem + 1'b1) : rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_div_unit.sv
// tb/tb_mod_div_unit.sv - directed self-checking bench for mod_div_unit (WIDTH 8 and 32)
module tb_mod_div_unit;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;

  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dbz32;
  logic [31:0] q32, r32;

  int compared = 0;
  int mismatched = 0;
  int lat;
  int seen;

  mod_div_unit #(.WIDTH(8)) dut8 (
    .CLK(CLK), .reset(reset), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  mod_div_unit #(.WIDTH(32)) dut32 (
    .CLK(CLK), .reset(reset), .start(start32), .signed_mode(sm32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic sm, input logic [7:0] av, input logic [7:0] bv, output int l);
    start8 = 1'b1; sm8 = sm; a8 = av; b8 = bv;
    @(posedge CLK); #1;
    start8 = 1'b0;
    l = 0;
    while (!done8 && l < 60) begin
      @(posedge CLK); #1;
      l++;
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_q", q8, 0);
    check("rst_r", r8, 0);
    check("rst_dbz", dbz8, 0);
    reset = 1'b0;
    @(posedge CLK); #1;

    run8(0, 8'd100, 8'd7, lat);
    check("u100_7_lat", lat, 10);
    check("u100_7_q", q8, 14);
    check("u100_7_r", r8, 2);
    check("u100_7_dbz", dbz8, 0);
    check("u100_7_busy_at_done", busy8, 0);
    @(posedge CLK); #1;
    check("done_single_pulse", done8, 0);
    check("results_hold", q8, 14);

    run8(1, 8'h9C, 8'h07, lat);
    check("s_m100_7_q", q8, 8'hF2);
    check("s_m100_7_r", r8, 8'hFE);

    run8(1, 8'h64, 8'hF9, lat);
    check("s_100_m7_q", q8, 8'hF2);
    check("s_100_m7_r", r8, 8'h02);

    run8(0, 8'd5, 8'd0, lat);
    check("u5_0_lat", lat, 2);
    check("u5_0_q", q8, 8'hFF);
    check("u5_0_r", r8, 8'h05);
    check("u5_0_dbz", dbz8, 1);

    run8(1, 8'd5, 8'd0, lat);
    check("s5_0_lat", lat, 2);
    check("s5_0_q", q8, 8'hFF);
    check("s5_0_r", r8, 8'h05);
    check("s5_0_dbz", dbz8, 1);

    run8(1, 8'h80, 8'hFF, lat);
    check("s_min_m1_q", q8, 8'h80);
    check("s_min_m1_r", r8, 8'h00);
    check("s_min_m1_dbz", dbz8, 0);

    run8(0, 8'd3, 8'd9, lat);
    check("u3_9_q", q8, 0);
    check("u3_9_r", r8, 3);

    // start pulsed while busy must be dropped
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd100; b8 = 8'd7;
    @(posedge CLK); #1;
    start8 = 1'b0;
    lat = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("ign_busy", busy8, 1);
    start8 = 1'b1; a8 = 8'd50; b8 = 8'd5;
    @(posedge CLK); #1;
    lat++;
    start8 = 1'b0;
    while (!done8 && lat < 60) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("ign_lat", lat, 10);
    check("ign_q", q8, 14);
    check("ign_r", r8, 2);
    seen = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (done8 || busy8) seen++;
    end
    check("ign_not_queued", seen, 0);

    // back-to-back: second start issued in the done cycle
    run8(1, 8'h9C, 8'h07, lat);
    check("b2b_first_done", done8, 1);
    check("b2b_first_q", q8, 8'hF2);
    run8(0, 8'd3, 8'd9, lat);
    check("b2b_second_lat", lat, 10);
    check("b2b_second_q", q8, 0);
    check("b2b_second_r", r8, 3);

    // abort during iteration
    run8(0, 8'd100, 8'd7, lat);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd9; b8 = 8'd2;
    @(posedge CLK); #1;
    start8 = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_q", q8, 0);
    check("abort_r", r8, 0);
    check("abort_dbz", dbz8, 0);
    seen = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (done8) seen++;
    end
    check("abort_no_done", seen, 0);

    run8(0, 8'd200, 8'd10, lat);
    check("u200_10_lat", lat, 10);
    check("u200_10_q", q8, 20);
    check("u200_10_r", r8, 0);

    start32 = 1'b1; sm32 = 1'b0; a32 = 32'hFFFF_FFFF; b32 = 32'd3;
    @(posedge CLK); #1;
    start32 = 1'b0;
    lat = 0;
    while (!done32 && lat < 80) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("w32_lat", lat, 34);
    check("w32_q", q32, 32'h5555_5555);
    check("w32_r", r32, 32'h0);
    check("w32_dbz", dbz32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
